// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-domain blocks.
//   spi_state_e      : frame state of a slave word engine (IDLE / ACTIVE).
//   SYNC_STAGES_DEF  : default depth of the input synchroniser chains.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Word-level handshake between the SPI slave engine and its consumer.
//   rx_data  : last completed received word (slave -> master)
//   rx_valid : rx_data holds an unconsumed word (slave -> master)
//   rx_ready : consumer accepts rx_data on a clk edge with rx_valid=1
//   tx_data  : reply word, sampled at each tx load point (master -> slave)
//   tx_taken : one-cycle pulse when tx_data was captured (slave -> master)
interface spi_slave_rx_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_taken;

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  tx_data,
        output tx_taken
    );

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output tx_data,
        input  tx_taken
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Synchroniser plus rise/fall detector for one asynchronous SPI pin.
//   clk, rst_n : system clock, synchronous active-low reset
//   async_in   : raw pin
//   level      : synchronised pin level
//   rise, fall : single-cycle edge indications (combinational from flops)
// RST_VAL sets the idle level the chain and history flop reset to.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES  = SYNC_STAGES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = ~hist_q & level;
    assign fall  = hist_q & ~level;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave word engine.
// Oversamples SCK/MOSI/CS_N, assembles MSB-first words from MOSI, hands each
// completed word to a valid/ready consumer and shifts a reply word out on MISO.
//   clk, rst_n    : system clock, synchronous active-low reset
//   SCK/MOSI/CS_N : asynchronous SPI pins from the master
//   MISO          : reply bit, 0 outside a frame
//   bus           : rx_data/rx_valid/rx_ready/tx_data/tx_taken handshake
//   frame_active  : frame in progress
//   frame_err     : pulse, CS_N released with a partial word
//   rx_overrun    : pulse, completed word dropped because rx_data unconsumed
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SCK,
    input  logic                 MOSI,
    input  logic                 CS_N,
    output logic                 MISO,
    spi_slave_rx_if.slave        bus,
    output logic                 frame_active,
    output logic                 frame_err,
    output logic                 rx_overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sck_level_unused, sck_rise, sck_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;
    logic cs_level, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(rst_n), .async_in(SCK),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .async_in(MOSI),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .async_in(CS_N),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shreg_q, rx_shreg_d;
    logic [DATA_W-1:0] tx_shreg_q, tx_shreg_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              word_seen_q, word_seen_d;
    logic              tx_taken_q, tx_taken_d;
    logic              frame_err_q, frame_err_d;
    logic              rx_overrun_q, rx_overrun_d;
    // Reset loads the CS_N chain with 1, so a pin held low would look like a
    // fall once the chain flushes. settle_q marks when the chain carries real
    // pin data; a frame may only start after CS_N has been seen high since.
    logic [SYNC_STAGES:0] settle_q, settle_d;
    logic              armed_q, armed_d;
    logic              complete;
    logic [DATA_W-1:0] new_word;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shreg_d   = rx_shreg_q;
        tx_shreg_d   = tx_shreg_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        word_seen_d  = word_seen_q;
        tx_taken_d   = 1'b0;
        frame_err_d  = 1'b0;
        rx_overrun_d = 1'b0;
        settle_d     = {settle_q[SYNC_STAGES-1:0], 1'b1};
        armed_d      = armed_q | (settle_q[SYNC_STAGES] & cs_level);
        complete     = 1'b0;
        new_word     = {rx_shreg_q[DATA_W-2:0], mosi_level};

        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (cs_fall && armed_q) begin
                    tx_shreg_d  = bus.tx_data;
                    tx_taken_d  = 1'b1;
                    rx_shreg_d  = '0;
                    word_seen_d = 1'b0;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sck_rise) begin
                    rx_shreg_d = new_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        complete    = 1'b1;
                        bit_cnt_d   = '0;
                        word_seen_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shreg_d = {tx_shreg_q[DATA_W-2:0], 1'b0};
                    end else if (word_seen_q) begin
                        // Word boundary: next reply word goes out from here.
                        tx_shreg_d = bus.tx_data;
                        tx_taken_d = 1'b1;
                    end
                end
                // A word finishing in the same cycle CS_N rises still counts.
                if (cs_rise) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    rx_shreg_d  = '0;
                    word_seen_d = 1'b0;
                    if ((bit_cnt_q != '0) && !complete) begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (rx_valid_q && !bus.rx_ready) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_data_d  = new_word;
                rx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_shreg_q   <= '0;
            tx_shreg_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            word_seen_q  <= 1'b0;
            tx_taken_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_overrun_q <= 1'b0;
            settle_q     <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shreg_q   <= rx_shreg_d;
            tx_shreg_q   <= tx_shreg_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            word_seen_q  <= word_seen_d;
            tx_taken_q   <= tx_taken_d;
            frame_err_q  <= frame_err_d;
            rx_overrun_q <= rx_overrun_d;
            settle_q     <= settle_d;
            armed_q      <= armed_d;
        end
    end

    assign frame_active = (state_q == ACTIVE);
    assign MISO         = (state_q == ACTIVE) & tx_shreg_q[DATA_W-1];
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_taken = tx_taken_q;
    assign frame_err    = frame_err_q;
    assign rx_overrun   = rx_overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: 50 MHz clk, ~2 MHz SCK, mode 0.
module tb_spi_slave_rx;

    localparam int DATA_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic SCK   = 1'b0;
    logic MOSI  = 1'b0;
    logic CS_N  = 1'b1;
    logic MISO, frame_active, frame_err, rx_overrun;

    spi_slave_rx_if #(.DATA_W(DATA_W)) bus ();

    spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .SCK(SCK), .MOSI(MOSI), .CS_N(CS_N),
        .MISO(MISO), .bus(bus), .frame_active(frame_active),
        .frame_err(frame_err), .rx_overrun(rx_overrun)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_taken = 0, n_ferr = 0, n_ovr = 0, n_vrise = 0;
    logic prev_v = 1'b0;
    logic [7:0] log_q[$];

    // Event monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.tx_taken) n_taken++;
        if (frame_err) n_ferr++;
        if (rx_overrun) n_ovr++;
        if (bus.rx_valid && !prev_v) n_vrise++;
        prev_v = bus.rx_valid;
        if (bus.rx_valid && bus.rx_ready) log_q.push_back(bus.rx_data);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name, input logic [7:0] exp);
        logic [7:0] v;
        if (log_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got=none want=%0h", name, exp);
        end else begin
            v = log_q.pop_front();
            check(name, 32'(v), 32'(exp));
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the top nbits of w MSB-first; MISO is sampled just before each
    // rise. endmode 1 raises CS_N in the middle of the last high phase.
    task automatic send_bits(input logic [7:0] w, input int nbits, input int endmode,
                             output logic [7:0] mw);
        mw = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            MOSI = w[7-k];
            wait_clks(12);
            mw[7-k] = MISO;
            SCK = 1'b1;
            if ((k == nbits - 1) && (endmode == 1)) begin
                wait_clks(6);
                CS_N = 1'b1;
                wait_clks(7);
            end else begin
                wait_clks(13);
            end
            SCK = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] mw, m1, m2;
        int t0, f0, o0, r0;

        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h5A, 8'h81, 8'h5A, 8'h81};

        bus.rx_ready = 1'b1;
        bus.tx_data  = 8'h00;

        // Reset state
        wait_clks(3);
        check("rst_frame_active", 32'(frame_active), 0);
        check("rst_miso", 32'(MISO), 0);
        check("rst_rx_valid", 32'(bus.rx_valid), 0);
        check("rst_rx_data", 32'(bus.rx_data), 0);
        check("rst_tx_taken", 32'(bus.tx_taken), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun", 32'(rx_overrun), 0);
        rst_n = 1'b1;
        wait_clks(10);

        // Single-word frames from the table
        foreach (vecs[v]) begin
            t0 = n_taken; f0 = n_ferr; r0 = n_vrise;
            bus.tx_data = vecs[v].tx;
            CS_N = 1'b0;
            wait_clks(12);
            check("vec_frame_active", 32'(frame_active), 1);
            send_bits(vecs[v].mosi, 8, 1, mw);
            wait_clks(20);
            check_log("vec_rx_data", vecs[v].exp_rx);
            check("vec_miso", 32'(mw), 32'(vecs[v].exp_miso));
            check("vec_tx_taken", 32'(n_taken - t0), 1);
            check("vec_frame_err", 32'(n_ferr - f0), 0);
            check("vec_valid_pulses", 32'(n_vrise - r0), 1);
            check("vec_frame_end", 32'(frame_active), 0);
        end

        // Two words in one frame, reply word changed after the first capture
        t0 = n_taken;
        bus.tx_data = 8'h3C;
        CS_N = 1'b0;
        wait_clks(12);
        bus.tx_data = 8'hF0;
        send_bits(8'h12, 8, 0, m1);
        send_bits(8'h34, 8, 1, m2);
        wait_clks(20);
        check_log("b2b_word0", 8'h12);
        check_log("b2b_word1", 8'h34);
        check("b2b_miso0", 32'(m1), 32'h3C);
        check("b2b_miso1", 32'(m2), 32'hF0);
        check("b2b_tx_taken", 32'(n_taken - t0), 2);

        // Overrun with consumer stalled
        o0 = n_ovr;
        @(posedge clk); #1 bus.rx_ready = 1'b0;
        CS_N = 1'b0;
        wait_clks(12);
        send_bits(8'h55, 8, 0, mw);
        send_bits(8'hAA, 8, 1, mw);
        wait_clks(20);
        check("ovr_valid", 32'(bus.rx_valid), 1);
        check("ovr_rx_data", 32'(bus.rx_data), 32'h55);
        check("ovr_pulses", 32'(n_ovr - o0), 1);
        check("ovr_nothing_taken", 32'(log_q.size()), 0);
        @(posedge clk); #1 bus.rx_ready = 1'b1;
        @(posedge clk); #1 bus.rx_ready = 1'b0;
        wait_clks(2);
        check("ovr_valid_cleared", 32'(bus.rx_valid), 0);
        check_log("ovr_accepted", 8'h55);
        @(posedge clk); #1 bus.rx_ready = 1'b1;

        // CS_N released after 5 bits
        f0 = n_ferr; r0 = n_vrise;
        CS_N = 1'b0;
        wait_clks(12);
        send_bits(8'hF8, 5, 1, mw);
        wait_clks(20);
        check("ferr_pulses", 32'(n_ferr - f0), 1);
        check("ferr_no_valid", 32'(n_vrise - r0), 0);
        check("ferr_frame_end", 32'(frame_active), 0);
        check("ferr_no_word", 32'(log_q.size()), 0);
        CS_N = 1'b0;
        wait_clks(12);
        send_bits(8'h0F, 8, 1, mw);
        wait_clks(20);
        check_log("ferr_next_word", 8'h0F);
        check("ferr_next_no_err", 32'(n_ferr - f0), 1);

        // Reset in the middle of a frame with CS_N held low
        bus.tx_data = 8'h77;
        CS_N = 1'b0;
        wait_clks(12);
        send_bits(8'hE0, 3, 0, mw);
        rst_n = 1'b0;
        wait_clks(1);
        rst_n = 1'b1;
        check("mid_rst_frame_active", 32'(frame_active), 0);
        check("mid_rst_miso", 32'(MISO), 0);
        check("mid_rst_rx_data", 32'(bus.rx_data), 0);
        check("mid_rst_rx_valid", 32'(bus.rx_valid), 0);
        t0 = n_taken;
        wait_clks(30);
        check("mid_rst_no_restart", 32'(frame_active), 0);
        check("mid_rst_no_taken", 32'(n_taken - t0), 0);
        CS_N = 1'b1;
        wait_clks(12);
        bus.tx_data = 8'h96;
        CS_N = 1'b0;
        wait_clks(12);
        check("mid_rst_restart", 32'(frame_active), 1);
        send_bits(8'hC3, 8, 1, mw);
        wait_clks(20);
        check_log("mid_rst_word", 8'hC3);
        check("mid_rst_miso_word", 32'(mw), 32'h96);

        // Last rise and CS_N rise in the same cycle, acceptance in that cycle
        f0 = n_ferr; o0 = n_ovr;
        @(posedge clk); #1 bus.rx_ready = 1'b0;
        bus.tx_data = 8'h00;
        CS_N = 1'b0;
        wait_clks(12);
        send_bits(8'h5A, 8, 0, mw);
        send_bits(8'h81, 7, 0, mw);
        MOSI = 1'b1;
        wait_clks(12);
        SCK  = 1'b1;
        CS_N = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 bus.rx_ready = 1'b1;
        @(posedge clk); #1 bus.rx_ready = 1'b0;
        #1;
        check("same_valid", 32'(bus.rx_valid), 1);
        check("same_rx_data", 32'(bus.rx_data), 32'h81);
        check("same_no_ferr", 32'(n_ferr - f0), 0);
        check("same_no_ovr", 32'(n_ovr - o0), 0);
        check_log("same_prev_word", 8'h5A);
        wait_clks(13);
        SCK = 1'b0;
        wait_clks(20);
        check("same_frame_end", 32'(frame_active), 0);
        check("same_valid_held", 32'(bus.rx_valid), 1);
        @(posedge clk); #1 bus.rx_ready = 1'b1;
        wait_clks(3);
        check_log("same_word_taken", 8'h81);
        check("same_valid_done", 32'(bus.rx_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI mode-0 slave word engine, directly downstream of the SCK start-detect stage, on the same system clock.
- Oversamples SCK, MOSI and CS_N into the clk domain and assembles MSB-first words from MOSI.
- Presents each completed word on a valid/ready interface and shifts a parallel reply word out on MISO.
- Flags framing errors (CS_N released mid-word) and overruns (word completed while the previous one is still unconsumed).

Parameters:
- DATA_W, 8, bits per SPI word (2..32).
- SYNC_STAGES, 2, synchroniser flops on SCK, MOSI and CS_N (≥2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- SCK  input  1  SPI clock from master, asynchronous.
- MOSI  input  1  SPI data from master, asynchronous.
- CS_N  input  1  SPI chip select, active-low, asynchronous.
- MISO  output  1  SPI data to master; 0 when CS_N is high (tristate is handled at top level).
- rx_data  output  DATA_W  last completed received word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts rx_data on a clk edge where rx_valid=1.
- tx_data  input  DATA_W  reply word; sampled at each tx load point.
- tx_taken  output  1  one-cycle pulse when tx_data was captured.
- frame_active  output  1  1 while the synchronised CS_N is low.
- frame_err  output  1  one-cycle pulse when CS_N rises with 0 < bit_cnt < DATA_W.
- rx_overrun  output  1  one-cycle pulse when a word is dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge, synchronous): every output 0, rx_data=0, bit_cnt=0, shift registers=0, FSM=IDLE. Synchroniser flops reset to SCK=0, MOSI=0, CS_N=1.
- Synchronisation: each input passes through SYNC_STAGES flops plus one history flop.
  - sck_rise = ~hist & sync; sck_fall = hist & ~sync; the same edge logic applies to CS_N.
  - Edge-detect latency is SYNC_STAGES+1 clk from the pin.
  - Operating constraint: SCK high and low times are each ≥ SYNC_STAGES+2 clk periods. Behaviour outside this constraint is undefined.
- FSM IDLE:
  - frame_active=0, bit_cnt held 0, MISO=0, SCK edges ignored.
  - On CS_N fall: load tx_shreg←tx_data, pulse tx_taken, go to ACTIVE.
- FSM ACTIVE:
  - frame_active=1; MISO = tx_shreg[DATA_W-1].
  - On sck_rise: rx_shreg ← {rx_shreg[DATA_W-2:0], MOSI_sync}, bit_cnt++.
  - When bit_cnt reaches DATA_W on a rise, the word completes: bit_cnt←0 and the word goes to the output register in the same cycle, so rx_valid rises one clk after that sck_rise is detected.
  - On sck_fall with bit_cnt≠0: tx_shreg shifts left and fills with 0.
  - On sck_fall with bit_cnt=0 and at least one word completed in the frame: reload tx_shreg←tx_data and pulse tx_taken.
- CS_N rise (ACTIVE→IDLE):
  - If 0<bit_cnt<DATA_W, pulse frame_err and discard the partial word; no rx_valid.
  - If the CS_N rise and the last sck_rise are detected in the same cycle, the word completes first and is not an error.
- Output handshake:
  - rx_valid stays high until a clk edge with rx_ready=1, then clears.
  - Completion while rx_valid=1 and rx_ready=0: new word dropped, rx_data unchanged, rx_overrun pulses.
  - Completion in the same cycle as acceptance (rx_valid=1, rx_ready=1): new word loaded, rx_valid stays 1, no overrun.
- Reset mid-frame: returns to IDLE immediately. A new frame needs a fresh CS_N fall, so CS_N still low at reset exit does not start a frame.
- bit_cnt width: $clog2(DATA_W+1).

Decomposition:
- Package spi_pkg: FSM state enum (IDLE, ACTIVE) and SYNC_STAGES default constant, shared with other SPI-domain blocks.
- One sub-module, spi_sync_edge: parameterised synchroniser plus rise/fall detector, instantiated for SCK, MOSI and CS_N. It replaces the single-edge detect used in the start-clock stage.

Test Plan:
- clk 50 MHz, SCK 2 MHz, CS_N low, MOSI sends 0xA5, rx_ready=1, tx_data=0x3C -> rx_valid 1-cycle pulse with rx_data=0xA5; MISO bits sampled on SCK rises = 0x3C; tx_taken pulses at CS_N fall; frame_err=0.
- Two back-to-back words 0x12, 0x34 in one frame, tx_data changed to 0xF0 after the first tx_taken -> rx_data 0x12 then 0x34; second MISO word = 0xF0; tx_taken pulses twice.
- rx_ready=0, send 0x55 then 0xAA -> rx_data stays 0x55, rx_valid=1, one rx_overrun pulse; rx_ready=1 for one cycle -> rx_valid=0.
- CS_N raised after 5 SCK rises -> frame_err single pulse, no rx_valid, frame_active→0; next full frame 0x0F received correctly.
- rst_n=0 for 1 clk after 3 bits of a frame, CS_N held low -> all outputs 0, FSM IDLE, no frame until CS_N toggles high→low; then 0xC3 received correctly.
- Last sck_rise detected in the same cycle as CS_N rise and rx_ready=1 with prior rx_valid=1 -> word loaded, no frame_err, no rx_overrun, rx_valid stays 1.
